// File: rtl/a2d_pkg.sv
// Shared types and timing constants for the A2D interface and its SPI engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a2d_pkg;

   // Conversion FSM encoding, kept as plain constants for legacy tools.
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t XFER1 = 2'd1;
   localparam state_t PAUSE = 2'd2;
   localparam state_t XFER2 = 2'd3;

   // Divider preload gives a 9-clock front porch before the first SCLK fall.
   localparam logic [4:0] SCLK_LOAD = 5'b10111;
   localparam logic [4:0] SMPL_PT   = 5'b01111;   // SCLK about to rise
   localparam logic [4:0] SHFT_PT   = 5'b11111;   // SCLK about to fall
   localparam logic [4:0] END_PT    = 5'b11110;   // stop before a 17th fall

   localparam int PAUSE_CLKS = 32;    // SS_n high between the two frames
   localparam int XFER_CLKS  = 520;   // SS_n low per frame

   // Pause counter preload: one edge is spent entering PAUSE and one more
   // registering the start strobe, so the counter covers the remaining edges.
   localparam logic [4:0] PAUSE_LOAD = 5'(PAUSE_CLKS - 2);

   // ADC command word: channel address sits in bits [13:11].
   function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// 16-bit SPI master frame engine: one frame per wrt strobe, SCLK = clk/32.
// Latency: SS_n falls 1 clk after wrt, rises 520 clks later with done.
// Backpressure: wrt is ignored while a frame is in progress (SS_n low).
module spi_mstr16
   import a2d_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   logic [4:0]  sclk_div;
   logic [4:0]  div_nxt;
   logic [4:0]  bit_cnt;
   logic [15:0] shft_tx;
   logic [15:0] shft_rx;
   logic        ss_q;
   logic        sclk_q;
   logic        xfer_end;

   assign div_nxt = sclk_div + 5'd1;

   // Last sample taken and SCLK still high: end the frame on this edge so
   // the ADC never sees a trailing falling edge.
   assign xfer_end = ~ss_q && (bit_cnt == 5'd16) && (sclk_div == END_PT);

   assign done    = xfer_end;
   assign rd_data = shft_rx;
   assign SS_n    = ss_q;
   assign SCLK    = sclk_q;
   assign MOSI    = shft_tx[15];

   // Frame sequencing, SCLK generation, MOSI shift on fall, MISO sample on rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_q     <= 1'b1;
         sclk_q   <= 1'b1;
         sclk_div <= SCLK_LOAD;
         bit_cnt  <= 5'd0;
         shft_tx  <= 16'h0000;
         shft_rx  <= 16'h0000;
      end else if (ss_q) begin
         if (wrt) begin
            ss_q     <= 1'b0;
            sclk_q   <= 1'b1;
            sclk_div <= SCLK_LOAD;
            bit_cnt  <= 5'd0;
            shft_tx  <= cmd;
         end
      end else if (xfer_end) begin
         ss_q     <= 1'b1;
         sclk_q   <= 1'b1;
         sclk_div <= SCLK_LOAD;
      end else begin
         sclk_div <= div_nxt;
         sclk_q   <= div_nxt[4];
         if (sclk_div == SMPL_PT) begin
            shft_rx <= {shft_rx[14:0], MISO};
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (sclk_div == SHFT_PT) begin
            shft_tx <= {shft_tx[14:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion sequencer: two SPI frames per request, result from the second.
// Latency: fixed 1073 clks from accepting strt_cnv to cnv_cmplt high.
// Backpressure: strt_cnv only accepted in IDLE; dropped while busy.
module a2d_intf
   import a2d_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] A2D_res,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   state_t      state;
   logic [2:0]  chnnl_q;
   logic [4:0]  pause_cnt;
   logic        wrt_q;
   logic        done;
   logic [15:0] rd_data;
   logic        cmplt_q;
   logic [11:0] res_q;
   logic [3:0]  rd_hi_unused;

   // The ADC's top nibble carries no conversion data.
   assign rd_hi_unused = rd_data[15:12];

   assign cnv_cmplt = cmplt_q;
   assign A2D_res   = res_q;

   spi_mstr16 u_spi (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (wrt_q),
      .cmd     (adc_cmd(chnnl_q)),
      .done    (done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO)
   );

   // Conversion FSM: frame 1 addresses the channel (its read data belongs to
   // the previous channel and is dropped), pause, frame 2 returns the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         chnnl_q   <= 3'd0;
         pause_cnt <= 5'd0;
         wrt_q     <= 1'b0;
         cmplt_q   <= 1'b0;
         res_q     <= 12'h000;
      end else begin
         wrt_q <= 1'b0;
         case (state)
            IDLE: begin
               if (strt_cnv) begin
                  chnnl_q <= chnnl;
                  cmplt_q <= 1'b0;
                  wrt_q   <= 1'b1;
                  state   <= XFER1;
               end
            end
            XFER1: begin
               if (done) begin
                  pause_cnt <= PAUSE_LOAD;
                  state     <= PAUSE;
               end
            end
            PAUSE: begin
               if (pause_cnt == 5'd0) begin
                  wrt_q <= 1'b1;
                  state <= XFER2;
               end else begin
                  pause_cnt <= pause_cnt - 5'd1;
               end
            end
            XFER2: begin
               if (done) begin
                  res_q   <= rd_data[11:0];
                  cmplt_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural ADC that answers each frame
// with the data of the channel addressed in the previous complete frame.
// Edge numbering: E0 is the edge that accepts strt_cnv; cyc counts posedges.
module tb_a2d_intf;
   import a2d_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        strt_cnv = 1'b0;
   logic [2:0]  chnnl = 3'd0;
   logic        MISO = 1'b0;
   logic        cnv_cmplt;
   logic [11:0] A2D_res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;

   a2d_intf u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .A2D_res   (A2D_res),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   // ADC model and frame monitor (all sampling on the falling clk edge)
   logic [15:0] adc_data [8];
   logic [2:0]  prev_ch = 3'd0;
   logic [15:0] resp = 16'h0000;
   int          k = 0;
   int          k_base = 0;
   logic [15:0] mosi_w [2];
   int          ss_fall [2];
   int          ss_rise [2];
   int          nf [2];
   int          nr [2];
   int          ff_off [2];
   int          per_min = 0;
   int          per_max = 0;
   logic        prev_ss = 1'b1;
   logic        prev_sclk = 1'b1;
   logic        prev_mosi = 1'b0;
   logic [15:0] mosi_acc = 16'h0000;
   int          nfall = 0;
   int          nrise = 0;
   int          fall_cyc = 0;
   int          first_fall = 0;
   int          last_fall = 0;

   initial forever begin
      @(negedge clk);
      if (prev_ss === 1'b1 && SS_n === 1'b0) begin
         fall_cyc   = cyc;
         nfall      = 0;
         nrise      = 0;
         mosi_acc   = 16'h0000;
         first_fall = -1;
         resp       = adc_data[prev_ch];
         MISO       = resp[15];
         if (k - k_base == 0) begin
            per_min = 100000;
            per_max = 0;
         end
      end else if (SS_n === 1'b0) begin
         if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
            nfall++;
            mosi_acc = {mosi_acc[14:0], prev_mosi};
            if (nfall == 1) begin
               first_fall = cyc - fall_cyc;
            end else if (k - k_base == 0) begin
               if (cyc - last_fall < per_min) per_min = cyc - last_fall;
               if (cyc - last_fall > per_max) per_max = cyc - last_fall;
            end
            last_fall = cyc;
         end
         if (prev_sclk === 1'b0 && SCLK === 1'b1) begin
            nrise++;
            if (nrise < 16) MISO = resp[15 - nrise];
         end
      end else if (prev_ss === 1'b0 && SS_n === 1'b1) begin
         if (k - k_base >= 0 && k - k_base < 2) begin
            mosi_w[k - k_base]  = mosi_acc;
            ss_fall[k - k_base] = fall_cyc;
            ss_rise[k - k_base] = cyc;
            nf[k - k_base]      = nfall;
            nr[k - k_base]      = nrise;
            ff_off[k - k_base]  = first_fall;
         end
         if (nfall == 16) prev_ch = mosi_acc[13:11];
         k++;
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
      prev_mosi = MOSI;
   end

   int e0 = 0;
   int lat = 0;

   // Issue strt_cnv (accepted at E0) and wait for cnv_cmplt; optionally pulse
   // strt_cnv again so it is sampled at edge E<pulse_at>. Called at a negedge.
   task automatic run_conv(input logic [2:0] ch, input int pulse_at, output int l);
      chnnl    = ch;
      strt_cnv = 1'b1;
      e0       = cyc + 1;
      k_base   = k;
      l        = -1;
      @(negedge clk);
      strt_cnv = 1'b0;
      chnnl    = ~ch;
      chk("cmplt_clr_on_accept", {31'd0, cnv_cmplt}, 32'd0);
      for (int i = 0; i < 1300; i++) begin
         if (cnv_cmplt === 1'b1) begin
            l = cyc - e0;
            break;
         end
         strt_cnv = (pulse_at > 0) && (cyc == e0 + pulse_at - 1);
         if (strt_cnv) chnnl = 3'd6;
         @(negedge clk);
      end
      strt_cnv = 1'b0;
   endtask

   task automatic chk_conv(input string p, input logic [15:0] word, input logic [11:0] res, input int l);
      chk({p, "_latency"},    l, 32'd1073);
      chk({p, "_frames"},     k - k_base, 32'd2);
      chk({p, "_mosi1"},      {16'd0, mosi_w[0]}, {16'd0, word});
      chk({p, "_mosi2"},      {16'd0, mosi_w[1]}, {16'd0, word});
      chk({p, "_ss_fall1"},   ss_fall[0] - e0, 32'd1);
      chk({p, "_ss_low1"},    ss_rise[0] - ss_fall[0], XFER_CLKS);
      chk({p, "_pause"},      ss_fall[1] - ss_rise[0], PAUSE_CLKS);
      chk({p, "_ss_rise2"},   ss_rise[1] - e0, 32'd1073);
      chk({p, "_res"},        {20'd0, A2D_res}, {20'd0, res});
   endtask

   int saw;

   initial begin
      adc_data[0] = 16'h0123;
      adc_data[1] = 16'h0111;
      adc_data[2] = 16'h0C3A;
      adc_data[3] = 16'h0A5C;
      adc_data[4] = 16'hF001;
      adc_data[5] = 16'h0777;
      adc_data[6] = 16'h0666;
      adc_data[7] = 16'h0FFF;

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n",  {31'd0, SS_n}, 32'd1);
      chk("rst_sclk",  {31'd0, SCLK}, 32'd1);
      chk("rst_mosi",  {31'd0, MOSI}, 32'd0);
      chk("rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
      chk("rst_res",   {20'd0, A2D_res}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic conversion on channel 3, plus SCLK shape in frame 1
      run_conv(3'd3, 0, lat);
      chk_conv("c3", 16'h1800, 12'hA5C, lat);
      chk("sclk_falls1",  nf[0], 32'd16);
      chk("sclk_rises1",  nr[0], 32'd16);
      chk("sclk_falls2",  nf[1], 32'd16);
      chk("sclk_first",   ff_off[0], 32'd9);
      chk("sclk_per_min", per_min, 32'd32);
      chk("sclk_per_max", per_max, 32'd32);
      repeat (50) @(negedge clk);
      chk("hold_cmplt", {31'd0, cnv_cmplt}, 32'd1);
      chk("hold_res",   {20'd0, A2D_res}, 32'h0A5C);
      chk("hold_ss_n",  {31'd0, SS_n}, 32'd1);

      // strt_cnv pulsed at E300 during frame 1 is ignored
      run_conv(3'd3, 300, lat);
      chk_conv("busy", 16'h1800, 12'hA5C, lat);

      // reset at E700 (frame 2) aborts the conversion
      chnnl    = 3'd5;
      strt_cnv = 1'b1;
      e0       = cyc + 1;
      @(negedge clk);
      strt_cnv = 1'b0;
      while (cyc < e0 + 699) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_ss_n",  {31'd0, SS_n}, 32'd1);
      chk("abort_sclk",  {31'd0, SCLK}, 32'd1);
      chk("abort_cmplt", {31'd0, cnv_cmplt}, 32'd0);
      chk("abort_res",   {20'd0, A2D_res}, 32'd0);
      saw = 0;
      repeat (1200) begin
         @(negedge clk);
         if (cnv_cmplt !== 1'b0 || SS_n !== 1'b1) saw = 1;
      end
      chk("abort_quiet", saw, 32'd0);
      run_conv(3'd2, 0, lat);
      chk_conv("after_rst", 16'h1000, 12'hC3A, lat);

      // back-to-back request in the cycle after cnv_cmplt rises
      run_conv(3'd7, 0, lat);
      chk_conv("b2b", 16'h3800, 12'hFFF, lat);

      // upper nibble discarded; strt_cnv on the cnv_cmplt edge is ignored
      run_conv(3'd4, 1073, lat);
      chk_conv("nibble", 16'h2000, 12'h001, lat);
      repeat (40) @(negedge clk);
      chk("coinc_frames", k - k_base, 32'd2);
      chk("coinc_cmplt",  {31'd0, cnv_cmplt}, 32'd1);
      chk("coinc_res",    {20'd0, A2D_res}, 32'h001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
